// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: client request/response handshake plus the memory-bus control
// signals (strobes and address) of mem_bus_master, bundled into one interface.
//
// The bidirectional data bus is deliberately not part of this bundle. It stays a
// plain inout net on the module so that tristate resolution remains an ordinary
// net between the master and the RAM.
//
// Parameters: DATA_W data width, ADDR_W address width.
// Modports:
//   master - the bus master: receives req_*, drives req_ready, rsp_* and mem_*.
//   slave  - the opposite side (client and memory), mirrored directions.
interface mem_bus_master_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-client initiator for the shared tristate memory bus.
//
// Accepts one request at a time (valid/ready) and sequences it onto the bus:
//   write: setup -> strobe -> hold, data driven in all three phases
//   read : access (WAIT_CYCLES+1 cycles, read strobe, bus released) -> turnaround
// Completion is a one-cycle rsp_valid pulse in the first idle cycle, in which
// req_ready is also high, so back-to-back requests incur no bubble.
//
// Optional feature (macro MEM_BUS_MASTER_VERIFY_EN): every write is followed by a
// readback (access + turnaround); rsp_rdata returns the readback and rsp_err
// flags a mismatch with the written data. Without the macro rsp_err is tied 0.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - mem_bus_master_if.master: req_*, rsp_*, mem_read/mem_write/mem_addr
//   mem_data - bidirectional data bus, driven only during write phases
module mem_bus_master #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_master_if.master    bus,
  inout  wire  [DATA_W-1:0]   mem_data
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWStrobe,
    StWHold,
    StRAccess,
    StRTurn
`ifdef MEM_BUS_MASTER_VERIFY_EN
    ,
    StVAccess,
    StVTurn
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
`ifdef MEM_BUS_MASTER_VERIFY_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  logic drive_en;
  logic rd_strobe;
  logic wr_strobe;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
`ifdef MEM_BUS_MASTER_VERIFY_EN
    rsp_err_d   = 1'b0;
`endif
    drive_en    = 1'b0;
    rd_strobe   = 1'b0;
    wr_strobe   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // req_ready also depends on rst_n, but flops cannot update during reset.
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          state_d = bus.req_write ? StWSetup : StRAccess;
        end
      end
      StWSetup: begin
        drive_en = 1'b1;
        state_d  = StWStrobe;
      end
      StWStrobe: begin
        drive_en  = 1'b1;
        wr_strobe = 1'b1;
        state_d   = StWHold;
      end
      StWHold: begin
        drive_en = 1'b1;
`ifdef MEM_BUS_MASTER_VERIFY_EN
        cnt_d   = '0;
        state_d = StVAccess;
`else
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
`endif
      end
      StRAccess: begin
        rd_strobe = 1'b1;
        if (cnt_q == CntLast) begin
          rdata_d = mem_data;
          state_d = StRTurn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRTurn: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
`ifdef MEM_BUS_MASTER_VERIFY_EN
      StVAccess: begin
        rd_strobe = 1'b1;
        if (cnt_q == CntLast) begin
          rdata_d = mem_data;
          state_d = StVTurn;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StVTurn: begin
        // rdata_q holds the readback captured on the last access edge.
        rsp_valid_d = 1'b1;
        rsp_err_d   = (rdata_q != wdata_q);
        state_d     = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Strobes and drive enable decode straight from the state register, so an
  // asynchronous reset drops them and releases the bus immediately.
  assign bus.req_ready = (state_q == StIdle) && rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_read  = rd_strobe;
  assign bus.mem_write = wr_strobe;
  assign bus.mem_addr  = addr_q;
  assign mem_data      = drive_en ? wdata_q : {DATA_W{1'bz}};

`ifdef MEM_BUS_MASTER_VERIFY_EN
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed steps followed by randomized transactions,
// checked against a request-level memory model (expected read data, latency and
// strobe counts are derived per request, not per cycle of the RTL).
module tb_mem_bus_master;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 9;
  localparam int unsigned WAIT = 1;
`ifdef MEM_BUS_MASTER_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  wire [DW-1:0] mem_data;

  mem_bus_master #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_data (mem_data)
  );

  // ---------------- RAM on the bus ----------------
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 0) return 32'h0400_0055;
    return 32'h9E37_79B9 * (a + 1);
  endfunction

  logic [DW-1:0] ram [512];
  bit            ram_wr [512];
  logic [DW-1:0] stuck_mask = '1;
  logic [DW-1:0] ram_rd;

  always_comb begin
    ram_rd = ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(int'(bus.mem_addr));
  end
  assign mem_data = bus.mem_read ? ram_rd : {DW{1'bz}};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      ram[bus.mem_addr]    <= mem_data & stuck_mask;
      ram_wr[bus.mem_addr] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] last_rd = '0;

  function automatic logic [DW-1:0] model_read(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge of the rsp_valid
  // cycle when keep=1 (so the next request can go back-to-back), otherwise one
  // cycle later after confirming the pulse dropped.
  task automatic run(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit keep);
    int e, lat, wr_cyc, rd_cyc, addr_bad, data_bad, both;
    bit got;
    logic [DW-1:0] exp_rd, stored;
    bit exp_err;
    int exp_lat, exp_rdc;
    check("ready_before_req", 32'(bus.req_ready), 32'(1));
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    exp_err = 1'b0;
    if (w) begin
      stored = d & stuck_mask;
      ref_mem[int'(a)] = stored;
      exp_lat = Verify ? int'(WAIT) + 6 : 4;
      exp_rd  = Verify ? stored : last_rd;
      exp_err = Verify && (stored != d);
      exp_rdc = Verify ? int'(WAIT) + 1 : 0;
    end else begin
      exp_rd  = model_read(int'(a));
      exp_lat = int'(WAIT) + 3;
      exp_rdc = int'(WAIT) + 1;
    end
    last_rd = exp_rd;
    e = 1; got = 0; lat = 0;
    wr_cyc = 0; rd_cyc = 0; addr_bad = 0; data_bad = 0; both = 0;
    while (!got && e <= 40) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1;
        lat = e;
      end else begin
        wr_cyc += int'(bus.mem_write);
        rd_cyc += int'(bus.mem_read);
        if (bus.mem_addr !== a) addr_bad++;
        if (w && e <= 3 && mem_data !== d) data_bad++;
        if (bus.mem_read && bus.mem_write) both++;
      end
      if (e == 1) begin
        // Junk on an unaccepted request must be ignored.
        bus.req_valid = keep;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
      end
      if (!got) begin
        @(posedge clk);
        e++;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("ready_in_rsp_cycle", 32'(bus.req_ready), 32'(1));
    check("mem_write_cycles", 32'(wr_cyc), 32'(w ? 1 : 0));
    check("mem_read_cycles", 32'(rd_cyc), 32'(exp_rdc));
    check("addr_stable", 32'(addr_bad), 32'(0));
    check("wdata_on_bus", 32'(data_bad), 32'(0));
    check("strobe_overlap", 32'(both), 32'(0));
    if (!keep) begin
      @(posedge clk);
      @(negedge clk);
      check("rsp_one_cycle", 32'(bus.rsp_valid), 32'(0));
    end
  endtask

  initial begin
    int found, bad;
    logic [DW-1:0] rd;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_mem_read", 32'(bus.mem_read), 32'(0));
    check("rst_mem_write", 32'(bus.mem_write), 32'(0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back
    run(1'b1, 9'h005, 32'hDEAD_BEEF, 1'b0);
    run(1'b0, 9'h005, 32'h0, 1'b0);
    check("readback_deadbeef", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Fresh RAM location
    run(1'b0, 9'h000, 32'h0, 1'b0);
    check("fresh_read_0", bus.rsp_rdata, 32'h0400_0055);

    // Back-to-back with req_valid held high
    run(1'b1, 9'h1FF, 32'h1234_5678, 1'b1);
    run(1'b0, 9'h1FF, 32'h0, 1'b0);
    check("b2b_read", bus.rsp_rdata, 32'h1234_5678);

    // Reset during the write strobe
    check("ready_before_abort", 32'(bus.req_ready), 32'(1));
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 9'h0AA;
    bus.req_wdata = 32'hA5A5_0F0F;
    @(posedge clk);
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_write) found = 1;
      else @(posedge clk);
    end
    check("abort_saw_strobe", 32'(found), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", 32'(bus.mem_write), 32'(0));
    check("abort_mem_read", 32'(bus.mem_read), 32'(0));
    check("abort_ready", 32'(bus.req_ready), 32'(0));
    check("abort_mem_addr", 32'(bus.mem_addr), 32'(0));
    last_rd = '0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_write) bad++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.rsp_valid) bad++;
    check("abort_no_rsp", 32'(bad), 32'(0));
    run(1'b0, 9'h0AA, 32'h0, 1'b0);
    run(1'b1, 9'h0AA, 32'h0BAD_F00D, 1'b0);
    run(1'b0, 9'h0AA, 32'h0, 1'b0);

`ifdef MEM_BUS_MASTER_VERIFY_EN
    // Readback through a RAM with bit 0 stuck at 0
    stuck_mask = ~32'h1;
    run(1'b1, 9'h010, 32'h0000_0001, 1'b0);
    check("verify_err_set", 32'(bus.rsp_err), 32'(1));
    check("verify_rdata_stuck", bus.rsp_rdata, 32'h0);
    run(1'b1, 9'h011, 32'h0000_0002, 1'b0);
    check("verify_err_clear", 32'(bus.rsp_err), 32'(0));
    stuck_mask = '1;
`endif

    // Randomized traffic over a small address pool so reads hit earlier writes
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7)) + ($urandom_range(0, 1) != 0 ? 9'h1F0 : 9'h000);
      run(1'($urandom), a, $urandom, (i != 23) && ($urandom_range(0, 1) != 0));
    end

    rd = model_read(5);
    run(1'b0, 9'h005, 32'h0, 1'b0);
    check("final_read_5", bus.rsp_rdata, rd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
